// File: rtl/console_tx.sv
// 8N1 UART transmitter for console output: sends one raw byte, or a 16-bit value as uppercase hex + CR LF.
// Define CONSOLE_TX_PREFIX_EN to prepend "0x" to every hex-mode request.
module console_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  char_in,
  input  logic [15:0] val,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

`ifdef CONSOLE_TX_PREFIX_EN
  localparam logic [2:0] LP_HEX_LAST = 3'd7;
`else
  localparam logic [2:0] LP_HEX_LAST = 3'd5;
`endif

  localparam logic [15:0] LP_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bitIdx;
  logic [2:0]  r_charIdx;
  logic        r_mode;
  logic [15:0] r_val;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;

  logic        w_baudTerm;
  logic        w_lastChar;
  logic [7:0]  w_firstChar;
  logic [7:0]  w_nextChar;

  // 10..15 map to 'A'..'F': 0x41 + (n - 10) == 0x37 + n
  function automatic logic [7:0] nibbleToAscii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hexChar(input logic [15:0] v, input logic [2:0] idx);
    logic [7:0] c;
`ifdef CONSOLE_TX_PREFIX_EN
    case (idx)
      3'd0:    c = 8'h30;
      3'd1:    c = 8'h78;
      3'd2:    c = nibbleToAscii(v[15:12]);
      3'd3:    c = nibbleToAscii(v[11:8]);
      3'd4:    c = nibbleToAscii(v[7:4]);
      3'd5:    c = nibbleToAscii(v[3:0]);
      3'd6:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
`else
    case (idx)
      3'd0:    c = nibbleToAscii(v[15:12]);
      3'd1:    c = nibbleToAscii(v[11:8]);
      3'd2:    c = nibbleToAscii(v[7:4]);
      3'd3:    c = nibbleToAscii(v[3:0]);
      3'd4:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
`endif
    return c;
  endfunction

  assign w_baudTerm  = (r_baud == LP_BAUD_LAST);
  assign w_lastChar  = r_mode ? (r_charIdx == LP_HEX_LAST) : 1'b1;
  assign w_firstChar = mode ? hexChar(val, 3'd0) : char_in;
  assign w_nextChar  = hexChar(r_val, r_charIdx + 3'd1);

  // Frame sequencer; a stop bit with characters left chains straight into the next start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bitIdx  <= '0;
      r_charIdx <= '0;
      r_mode    <= 1'b0;
      r_val     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (start) begin
            r_mode    <= mode;
            r_val     <= val;
            r_shift   <= w_firstChar;
            r_charIdx <= '0;
            r_bitIdx  <= '0;
            r_baud    <= '0;
            r_busy    <= 1'b1;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_baudTerm) begin
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_tx     <= r_shift[0];
            r_state  <= DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baudTerm) begin
            r_baud <= '0;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[r_bitIdx + 3'd1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baudTerm) begin
            r_baud <= '0;
            if (w_lastChar) begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_charIdx <= r_charIdx + 3'd1;
              r_shift   <= w_nextChar;
              r_tx      <= 1'b0;
              r_state   <= START;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/console_tx.md
Name: console_tx

Overview:
- Output side of the keyboard/console path.
- The mode FSM consumes scan codes. This block sends prompts, echoes and results back to the host as 8N1 UART serial frames.
- Two request types:
  - single-character mode: one raw byte.
  - hex mode: a 16-bit value rendered as four uppercase ASCII hex digits followed by CR LF.
- It sits between the mode FSM / ALU result path and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range 1 to 65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled each rising edge.
- mode  input  1  0 = single char, 1 = hex value; latched with start.
- char_in  input  8  byte to send in char mode; latched with start.
- val  input  16  value to print in hex mode; latched with start.
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle pulse when the final stop bit completes.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (sync, active-high):
  - tx=1, busy=0, done=0.
  - FSM to IDLE; bit counter, char index and baud counter cleared.
- States: IDLE, START, DATA, STOP.
- Accepting a request:
  - start is accepted only when the FSM is in IDLE (busy=0).
  - At the accepting edge, mode/char_in/val are latched, busy goes to 1, tx goes to 0, and the FSM enters START with char index 0.
  - start while busy=1 is ignored; latched data is unchanged.
- Bit timing:
  - Every bit (start, 8 data, stop) holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1; each bit boundary is the terminal count.
- DATA: bits go out LSB first, bit index 0..7, then STOP with tx=1.
- Character sequence:
  - Char mode: one character, char_in.
  - Hex mode: six characters — val[15:12], val[11:8], val[7:4], val[3:0], 0x0D, 0x0A.
  - Nibble encoding: 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10), i.e. uppercase.
- End of a stop bit:
  - If more characters remain: char index increments and the FSM goes straight to START (tx=0) on the same edge. No idle gap between characters.
  - Otherwise: FSM to IDLE, tx=1, busy=0, done=1 for exactly one cycle.
- Frame and request lengths:
  - One frame is 10*CLKS_PER_BIT cycles.
  - A char request keeps busy high for 10*CLKS_PER_BIT cycles.
  - A hex request keeps busy high for 60*CLKS_PER_BIT cycles.
- Back-to-back requests: start asserted in the cycle done=1 is accepted (busy=0 in that cycle), giving zero idle cycles between requests.
- Reset mid-frame: tx=1 on the next cycle and the request is abandoned; no done pulse.
- CLKS_PER_BIT=1: each bit lasts one cycle; the same sequencing applies.
- Outputs are registered; tx has no combinational path from inputs.

Optional Feature:
- Macro: CONSOLE_TX_PREFIX_EN.
- Defined: hex mode emits "0x" (0x30, 0x78) before the four digits.
  - Eight characters per hex request.
  - busy lasts 80*CLKS_PER_BIT cycles.
- Undefined: six characters, as above.
- Char mode is unaffected either way.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Char mode, char_in=0x5A, one-cycle start:
  - tx sequence per 4-cycle bit: 0 | 0 1 0 1 1 0 1 0 | 1.
  - busy high for exactly 40 cycles; done pulses once at the end.
- Hex mode, val=0x1A3F:
  - Decoded bytes 0x31 0x41 0x33 0x46 0x0D 0x0A.
  - 240 busy cycles; no idle gap between frames.
  - With CONSOLE_TX_PREFIX_EN: 0x30 0x78 prepended, 320 cycles.
- Boundary values:
  - val=0x0000 -> "0000\r\n".
  - val=0xFFFF -> "FFFF\r\n".
  - val=0x9A00 -> bytes 0x39 0x41 0x30 0x30 (checks the 9/A edge).
- Busy handling:
  - start with char_in=0x55 pulsed mid-request: ignored, output unchanged.
  - start asserted in the done cycle: accepted; the next start bit begins the following cycle.
- Reset mid-frame: rst during the third data bit of a hex request -> tx=1 and busy=0 next cycle, no done pulse; a subsequent char request for 0x41 transmits correctly.
- CLKS_PER_BIT=1, char 0x0D: frame 0 1 0 1 1 0 0 0 0 1 on consecutive cycles; busy for 10 cycles.
